dac_spi_rx: RTL and testbench

- Receive-side model of the serial DAC link: the peripheral end that the DAC-driving SPI master talks to.
- Samples mosi while cs is low and deserialises 32-bit MSB-first frames.
- Decodes each frame as a command and maintains a bank of channel input/DAC registers plus an internal-reference enable.
- Used as a bench-side or on-chip responder so master traffic is checked by value, not by waveform.

---
 rtl/dac_spi_rx_pkg.sv | 38 +++
 rtl/dac_spi_rx_if.sv | 27 ++
 rtl/dac_spi_rx_spi_frame_shifter.sv | 42 ++++
 rtl/dac_spi_rx.sv | 171 +++++++++++++++++
 tb/tb_dac_spi_rx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_rx_pkg.sv
// dac_spi_pkg: shared constants, field positions and enums for the DAC SPI receiver.
// Optional build macro used by the top: DAC_SPI_RX_STATS_EN.
package dac_spi_pkg;

  localparam int FRAME_BITS = 32;
  localparam int DATA_W     = 12;

  // Field positions inside the 32-bit frame
  localparam int CMD_MSB  = 27;
  localparam int CMD_LSB  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 20;
  localparam int DATA_MSB = 19;
  localparam int DATA_LSB = 8;
  localparam int REF_BIT  = 0;

  // Bit counter must hold FRAME_BITS+1 so over-long frames stay distinguishable
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef enum logic [3:0] {
    CMD_WR_IN  = 4'h0,
    CMD_UPD    = 4'h1,
    CMD_WR_UPD = 4'h3,
    CMD_SETUP  = 4'h8
  } cmd_t;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    IDLE   = 2'd1,
    SHIFT  = 2'd2,
    DECODE = 2'd3
  } rx_state_t;

endpackage

// File: rtl/dac_spi_rx_if.sv
// dac_spi_rx_if: serial link plus readback/update signals of the DAC SPI receiver.
// master = the side driving cs/mosi/rd_ch, slave = dac_spi_rx.
interface dac_spi_rx_if;
  import dac_spi_pkg::*;

  logic              cs;
  logic              mosi;
  logic [2:0]        rd_ch;
  logic [DATA_W-1:0] rd_code;
  logic              ref_en;
  logic              upd_valid;
  logic [3:0]        upd_ch;
  logic [DATA_W-1:0] upd_code;
  logic              frame_err;
  logic              cmd_err;

  modport master (
    output cs, mosi, rd_ch,
    input  rd_code, ref_en, upd_valid, upd_ch, upd_code, frame_err, cmd_err
  );

  modport slave (
    input  cs, mosi, rd_ch,
    output rd_code, ref_en, upd_valid, upd_ch, upd_code, frame_err, cmd_err
  );

endinterface

// File: rtl/dac_spi_rx_spi_frame_shifter.sv
// spi_frame_shifter: MSB-first deserialiser with saturating bit counter and cs-rise detect.
module spi_frame_shifter
  import dac_spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cs,
  input  logic                  i_mosi,
  input  logic                  i_start,
  input  logic                  i_shift,
  output logic [FRAME_BITS-1:0] o_word,
  output logic                  o_cnt_ok,
  output logic                  o_frame_done
);

  logic [FRAME_BITS-1:0] r_word;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cs_q;

  // Shift bits in at the LSB; start restarts the count at one bit received
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_cs_q <= 1'b1;
    end else begin
      r_cs_q <= i_cs;
      if (i_start) begin
        r_word <= {r_word[FRAME_BITS-2:0], i_mosi};
        r_cnt  <= CNT_W'(1);
      end else if (i_shift) begin
        r_word <= {r_word[FRAME_BITS-2:0], i_mosi};
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_word       = r_word;
  assign o_cnt_ok     = (r_cnt == CNT_FULL);
  assign o_frame_done = i_cs & ~r_cs_q;

endmodule

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: SPI peripheral model for a multi-channel DAC (input/DAC register bank,
// reference enable, update/error pulses).
// Optional build macro DAC_SPI_RX_STATS_EN adds saturating good_frames/bad_frames counters.
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DAC_SPI_RX_STATS_EN
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames,
`endif
  dac_spi_rx_if.slave bus
);

  rx_state_t             r_state;
  logic [DATA_W-1:0]     r_in  [NUM_CH];
  logic [DATA_W-1:0]     r_dac [NUM_CH];
  logic                  r_ref_en;
  logic                  r_upd_valid;
  logic [3:0]            r_upd_ch;
  logic [DATA_W-1:0]     r_upd_code;
  logic                  r_frame_err;
  logic                  r_cmd_err;

  logic [FRAME_BITS-1:0] w_word;
  logic                  w_cnt_ok;
  logic                  w_frame_done;
  logic                  w_start;
  logic                  w_shift;
  logic [3:0]            w_cmd;
  logic [3:0]            w_addr;
  logic [DATA_W-1:0]     w_data;
  logic                  w_all;
  logic                  w_addr_ok;
  logic [DATA_W-1:0]     w_sel_in;
  logic [DATA_W-1:0]     w_rd_code;

  // A new frame begins whenever cs low is seen in IDLE or in the DECODE cycle
  assign w_start = ~bus.cs & ((r_state == IDLE) | (r_state == DECODE));
  assign w_shift = ~bus.cs & (r_state == SHIFT);

  spi_frame_shifter u_shifter (
    .clk          (clk),
    .rst          (rst),
    .i_cs         (bus.cs),
    .i_mosi       (bus.mosi),
    .i_start      (w_start),
    .i_shift      (w_shift),
    .o_word       (w_word),
    .o_cnt_ok     (w_cnt_ok),
    .o_frame_done (w_frame_done)
  );

  assign w_cmd     = w_word[CMD_MSB:CMD_LSB];
  assign w_addr    = w_word[ADDR_MSB:ADDR_LSB];
  assign w_data    = w_word[DATA_MSB:DATA_LSB];
  assign w_all     = (w_addr == ADDR_ALL);
  assign w_addr_ok = w_all | (32'(w_addr) < NUM_CH);

  // Input register reported on a copy; a broadcast copy reports channel 0
  always_comb begin
    w_sel_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_all ? (i == 0) : (w_addr == 4'(i))) w_sel_in = r_in[i];
    end
  end

  // Combinational readback of the selected DAC register
  always_comb begin
    w_rd_code = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == 3'(i)) w_rd_code = r_dac[i];
    end
  end

  // Receive FSM, command decode and register bank with registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SYNC;
      r_ref_en    <= 1'b0;
      r_upd_valid <= 1'b0;
      r_upd_ch    <= '0;
      r_upd_code  <= '0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_in[i]  <= '0;
        r_dac[i] <= '0;
      end
    end else begin
      r_upd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
      case (r_state)
        SYNC:   if (bus.cs) r_state <= IDLE;
        IDLE:   if (!bus.cs) r_state <= SHIFT;
        SHIFT: begin
          if (w_frame_done) begin
            if (w_cnt_ok) begin
              r_state <= DECODE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        DECODE: begin
          r_state <= bus.cs ? IDLE : SHIFT;
          if (!w_addr_ok) begin
            r_cmd_err <= 1'b1;
          end else begin
            case (w_cmd)
              CMD_WR_IN: begin
                for (int i = 0; i < NUM_CH; i++)
                  if (w_all || (w_addr == 4'(i))) r_in[i] <= w_data;
              end
              CMD_UPD: begin
                for (int i = 0; i < NUM_CH; i++)
                  if (w_all || (w_addr == 4'(i))) r_dac[i] <= r_in[i];
                r_upd_valid <= 1'b1;
                r_upd_ch    <= w_addr;
                r_upd_code  <= w_sel_in;
              end
              CMD_WR_UPD: begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (w_all || (w_addr == 4'(i))) begin
                    r_in[i]  <= w_data;
                    r_dac[i] <= w_data;
                  end
                end
                r_upd_valid <= 1'b1;
                r_upd_ch    <= w_addr;
                r_upd_code  <= w_data;
              end
              CMD_SETUP: r_ref_en <= w_word[REF_BIT];
              default:   r_cmd_err <= 1'b1;
            endcase
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

`ifdef DAC_SPI_RX_STATS_EN
  // Saturating frame statistics: every decoded frame, and every error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_frames <= '0;
      bad_frames  <= '0;
    end else begin
      if ((r_state == DECODE) && (good_frames != 16'hFFFF))
        good_frames <= good_frames + 16'd1;
      if ((r_frame_err || r_cmd_err) && (bad_frames != 16'hFFFF))
        bad_frames <= bad_frames + 16'd1;
    end
  end
`endif

  assign bus.rd_code   = w_rd_code;
  assign bus.ref_en    = r_ref_en;
  assign bus.upd_valid = r_upd_valid;
  assign bus.upd_ch    = r_upd_ch;
  assign bus.upd_code  = r_upd_code;
  assign bus.frame_err = r_frame_err;
  assign bus.cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb_dac_spi_rx: directed and randomized frames against a behavioural register-bank model.
module tb_dac_spi_rx;
  import dac_spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  dac_spi_rx_if bus ();
`ifdef DAC_SPI_RX_STATS_EN
  logic [15:0] good_frames;
  logic [15:0] bad_frames;
`endif

  dac_spi_rx dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DAC_SPI_RX_STATS_EN
    .good_frames (good_frames),
    .bad_frames  (bad_frames),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [11:0] m_in  [8];
  logic [11:0] m_dac [8];
  logic        m_ref;
  logic        exp_upd, exp_ferr, exp_cerr;
  logic [3:0]  exp_ch;
  logic [11:0] exp_code;
  bit          pending;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_in[i]  = '0;
      m_dac[i] = '0;
    end
    m_ref = 1'b0;
  endtask

  // What a frame of n bits should do to the register bank and the pulses
  task automatic model(input logic [127:0] w, input int n);
    int cmd, addr, data, src;
    exp_upd = 0; exp_ferr = 0; exp_cerr = 0; exp_ch = 0; exp_code = 0;
    if (n != 32) begin
      exp_ferr = 1;
      return;
    end
    cmd  = int'((w >> 24) & 128'hF);
    addr = int'((w >> 20) & 128'hF);
    data = int'((w >> 8) & 128'hFFF);
    if (addr >= 8 && addr != 15) begin
      exp_cerr = 1;
    end else if (cmd == 0) begin
      for (int c = 0; c < 8; c++) if (addr == 15 || addr == c) m_in[c] = 12'(data);
    end else if (cmd == 1) begin
      src = (addr == 15) ? 0 : addr;
      exp_upd = 1; exp_ch = 4'(addr); exp_code = m_in[src];
      for (int c = 0; c < 8; c++) if (addr == 15 || addr == c) m_dac[c] = m_in[c];
    end else if (cmd == 3) begin
      exp_upd = 1; exp_ch = 4'(addr); exp_code = 12'(data);
      for (int c = 0; c < 8; c++)
        if (addr == 15 || addr == c) begin
          m_in[c] = 12'(data);
          m_dac[c] = 12'(data);
        end
    end else if (cmd == 8) begin
      m_ref = w[0];
    end else begin
      exp_cerr = 1;
    end
  endtask

  task automatic check_decode();
    chk("upd_valid", 32'(bus.upd_valid), 32'(exp_upd));
    chk("cmd_err", 32'(bus.cmd_err), 32'(exp_cerr));
    chk("frame_err_dec", 32'(bus.frame_err), 32'(0));
    chk("ref_en", 32'(bus.ref_en), 32'(m_ref));
    if (exp_upd) begin
      chk("upd_ch", 32'(bus.upd_ch), 32'(exp_ch));
      chk("upd_code", 32'(bus.upd_code), 32'(exp_code));
    end
  endtask

  task automatic check_quiet();
    chk("quiet_pulses", {29'd0, bus.upd_valid, bus.cmd_err, bus.frame_err}, 32'(0));
  endtask

  task automatic check_regs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.rd_ch = 3'(c);
      #1;
      chk($sformatf("rd_code[%0d]", c), 32'(bus.rd_code), 32'(m_dac[c]));
    end
  endtask

  // Drive n bits MSB first; optionally check the previous frame's decode at the first edge
  task automatic drive_bits(input logic [127:0] w, input int n, input bit chk_prev);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.cs   = 1'b0;
      bus.mosi = w[n-1-k];
      if (k == 0 && chk_prev) begin
        @(posedge clk);
        #1;
        check_decode();
      end
    end
  endtask

  task automatic raise_cs();
    @(negedge clk);
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    @(posedge clk);
    #1;
    chk("frame_err", 32'(bus.frame_err), 32'(exp_ferr));
    chk("early_upd", 32'(bus.upd_valid), 32'(0));
    chk("early_cmd_err", 32'(bus.cmd_err), 32'(0));
  endtask

  task automatic flush();
    if (pending) begin
      @(posedge clk);
      #1;
      check_decode();
      @(posedge clk);
      #1;
      check_quiet();
      pending = 0;
    end
  endtask

  task automatic send(input logic [127:0] w, input int n, input bit b2b);
    bit join_prev;
    join_prev = pending && b2b;
    if (!join_prev) flush();
    drive_bits(w, n, join_prev);
    model(w, n);
    raise_cs();
    pending = 1;
  endtask

  logic [127:0] rw;
  int           rn;
  logic [3:0]   rcmd, raddr;

  initial begin
    rst = 1'b1; bus.cs = 1'b1; bus.mosi = 1'b0; bus.rd_ch = 3'd0;
    pending = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_pulses", {29'd0, bus.upd_valid, bus.cmd_err, bus.frame_err}, 32'(0));
    chk("rst_ref_en", 32'(bus.ref_en), 32'(0));
    chk("rst_upd_ch", 32'(bus.upd_ch), 32'(0));
    chk("rst_upd_code", 32'(bus.upd_code), 32'(0));
    check_regs();

    // Directed frames
    send(128'h08000001, 32, 0);
    send(128'h030ABC00, 32, 0);
    flush();
    check_regs();
    send(128'h00512300, 32, 0);
    send(128'h01500000, 32, 0);
    flush();
    check_regs();
    send(128'h0FFFFFFF, 31, 0);
    send(128'h1FFFFFFFF, 33, 0);
    send(128'h07000000, 32, 0);
    send(128'h03900000, 32, 0);
    send(128'h03300100, 32, 1);
    send(128'h00100200, 32, 1);
    send(128'h01100000, 32, 1);
    flush();
    check_regs();

    // Reset pulse in the middle of a frame; the rest of that frame must be ignored
    drive_bits(128'h03F8, 16, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_bits(128'h0000, 16, 0);
    exp_upd = 0; exp_ferr = 0; exp_cerr = 0;
    raise_cs();
    pending = 1;
    flush();
    check_regs();
    send(128'h03F80000, 32, 0);
    flush();
    check_regs();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom % 6)
        0: rcmd = 4'h0;
        1: rcmd = 4'h1;
        2: rcmd = 4'h3;
        3: rcmd = 4'h8;
        4: rcmd = 4'($urandom);
        default: rcmd = 4'h3;
      endcase
      raddr = (($urandom % 10) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      rw = {$urandom, $urandom, $urandom, 4'($urandom), rcmd, raddr, 12'($urandom), 8'($urandom)};
      case ($urandom % 10)
        0: begin
          rn = $urandom_range(1, 40);
          if (rn == 32) rn = 31;
        end
        1: rn = 96;
        default: rn = 32;
      endcase
      send(rw, rn, bit'($urandom % 2));
    end
    flush();
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
